// File: rtl/vector_writer.sv
// vector_writer: ordered (X, Y) capture buffer, filled over a valid/ready write port and drained oldest-first.
// Build macro VECTOR_WRITER_OVERWRITE_EN: writes while full replace the oldest pair instead of stalling.
//   state | meaning
//   IDLE  | accepting writes, waiting for start_read
//   DRAIN | presenting stored pairs oldest-first, writes blocked
module vector_writer #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 150,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_x,
    input  logic [WIDTH-1:0] wr_y,
    input  logic             start_read,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_x,
    output logic [WIDTH-1:0] rd_y,
    output logic             rd_last,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             busy
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     raddr;
    logic [CW-1:0]     count_q, count_d;
    logic              rd_valid_q, rd_valid_d;
    logic [WIDTH-1:0]  rd_x_q, rd_x_d;
    logic [WIDTH-1:0]  rd_y_q, rd_y_d;
    logic [WIDTH-1:0]  pf_x_q, pf_x_d;
    logic [WIDTH-1:0]  pf_y_q, pf_y_d;
    logic              wr_hs;

    logic [WIDTH-1:0]  mem_x [DEPTH];
    logic [WIDTH-1:0]  mem_y [DEPTH];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign busy    = (state_q == DRAIN);
    assign rd_last = rd_valid_q && (count_q == CW'(1));
`ifdef VECTOR_WRITER_OVERWRITE_EN
    assign wr_ready = (state_q == IDLE);
`else
    assign wr_ready = (state_q == IDLE) && !full;
`endif
    assign wr_hs    = wr_valid && wr_ready;

    assign rd_valid = rd_valid_q;
    assign rd_x     = rd_x_q;
    assign rd_y     = rd_y_q;
    assign count    = count_q;

    // raddr selects the pair the prefetch register must hold after this edge:
    // the oldest entry in IDLE, the entry after the presented one in DRAIN.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_valid_d = rd_valid_q;
        rd_x_d     = rd_x_q;
        rd_y_d     = rd_y_q;
        raddr      = rd_ptr_q;

        case (state_q)
            IDLE: begin
                if (wr_hs) begin
                    wr_ptr_d = ptr_inc(wr_ptr_q);
`ifdef VECTOR_WRITER_OVERWRITE_EN
                    if (full) begin
                        rd_ptr_d = ptr_inc(rd_ptr_q);
                    end else begin
                        count_d = count_q + 1'b1;
                    end
`else
                    count_d = count_q + 1'b1;
`endif
                end
                if (start_read && (!empty || wr_hs)) begin
                    state_d = DRAIN;
                end
                raddr = rd_ptr_d;
            end
            DRAIN: begin
                if (!rd_valid_q) begin
                    rd_valid_d = 1'b1;
                    rd_x_d     = pf_x_q;
                    rd_y_d     = pf_y_q;
                    raddr      = ptr_inc(rd_ptr_q);
                end else if (rd_ready) begin
                    count_d = count_q - 1'b1;
                    if (count_q == CW'(1)) begin
                        state_d    = IDLE;
                        rd_valid_d = 1'b0;
                        wr_ptr_d   = '0;
                        rd_ptr_d   = '0;
                        raddr      = '0;
                    end else begin
                        rd_ptr_d = ptr_inc(rd_ptr_q);
                        rd_x_d   = pf_x_q;
                        rd_y_d   = pf_y_q;
                        raddr    = ptr_inc(rd_ptr_d);
                    end
                end else begin
                    raddr = ptr_inc(rd_ptr_q);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Forward the incoming pair when it lands on the slot being fetched, so a
    // start_read issued alongside a write to an empty buffer sees fresh data.
    always_comb begin
        pf_x_d = mem_x[raddr];
        pf_y_d = mem_y[raddr];
        if (wr_hs && (raddr == wr_ptr_q)) begin
            pf_x_d = wr_x;
            pf_y_d = wr_y;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_hs) begin
            mem_x[wr_ptr_q] <= wr_x;
            mem_y[wr_ptr_q] <= wr_y;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_x_q     <= '0;
            rd_y_q     <= '0;
            pf_x_q     <= '0;
            pf_y_q     <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
            rd_x_q     <= rd_x_d;
            rd_y_q     <= rd_y_d;
            pf_x_q     <= pf_x_d;
            pf_y_q     <= pf_y_d;
        end
    end

    a_ptr_range: assert property (@(posedge clk) disable iff (rst)
        (wr_ptr_q < PW'(DEPTH)) && (rd_ptr_q < PW'(DEPTH)));

    a_count_range: assert property (@(posedge clk) disable iff (rst)
        count_q <= CW'(DEPTH));

    a_rd_hold: assert property (@(posedge clk) disable iff (rst)
        (rd_valid_q && !rd_ready) |=>
            (rd_valid_q && $stable(rd_x_q) && $stable(rd_y_q) && $stable(rd_last)));

    a_no_write_in_drain: assert property (@(posedge clk) disable iff (rst)
        (state_q == DRAIN) |-> !wr_ready);

endmodule

// File: tb/tb_vector_writer.sv
// tb_vector_writer: queue-based reference model checked every cycle, plus directed literal checks.
module tb_vector_writer;

    localparam int WIDTH = 20;
    localparam int DEPTH = 150;
`ifdef VECTOR_WRITER_OVERWRITE_EN
    localparam bit OVW = 1'b1;
`else
    localparam bit OVW = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             wr_valid = 1'b0;
    logic             start_read = 1'b0;
    logic             rd_ready = 1'b0;
    logic [WIDTH-1:0] wr_x = '0;
    logic [WIDTH-1:0] wr_y = '0;
    logic             wr_ready;
    logic             rd_valid;
    logic [WIDTH-1:0] rd_x;
    logic [WIDTH-1:0] rd_y;
    logic             rd_last;
    logic [7:0]       count;
    logic             full;
    logic             empty;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vector_writer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_x       (wr_x),
        .wr_y       (wr_y),
        .start_read (start_read),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_x       (rd_x),
        .rd_y       (rd_y),
        .rd_last    (rd_last),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .busy       (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: stored pairs as a queue, head is the pair on rd_x/rd_y.
    logic [2*WIDTH-1:0] mq[$];
    bit m_drain = 1'b0;
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        bit can_wr;
        can_wr = !m_drain && (OVW || mq.size() < DEPTH);
        if (rst) begin
            mq.delete();
            m_drain = 1'b0;
            m_valid = 1'b0;
        end else if (m_drain) begin
            if (!m_valid) begin
                m_valid = 1'b1;
            end else if (rd_ready) begin
                void'(mq.pop_front());
                if (mq.size() == 0) begin
                    m_drain = 1'b0;
                    m_valid = 1'b0;
                end
            end
        end else begin
            if (wr_valid && can_wr) begin
                if (mq.size() == DEPTH) void'(mq.pop_front());
                mq.push_back({wr_x, wr_y});
            end
            if (start_read && mq.size() > 0) m_drain = 1'b1;
        end
    end

    always @(negedge clk) begin
        check("wr_ready", wr_ready, !m_drain && (OVW || mq.size() < DEPTH));
        check("rd_valid", rd_valid, m_valid);
        check("rd_last", rd_last, m_valid && mq.size() == 1);
        check("count", count, mq.size());
        check("full", full, mq.size() == DEPTH);
        check("empty", empty, mq.size() == 0);
        check("busy", busy, m_drain);
        if (m_valid && mq.size() > 0) begin
            check("rd_x", rd_x, mq[0][2*WIDTH-1:WIDTH]);
            check("rd_y", rd_y, mq[0][WIDTH-1:0]);
        end
    end

    // Log of every read handshake the DUT performs.
    logic [WIDTH-1:0] log_x[$];
    logic [WIDTH-1:0] log_y[$];
    bit               log_last[$];

    always @(posedge clk) begin
        if (!rst && rd_valid && rd_ready) begin
            log_x.push_back(rd_x);
            log_y.push_back(rd_y);
            log_last.push_back(rd_last);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    task automatic clear_log();
        log_x.delete();
        log_y.delete();
        log_last.delete();
    endtask

    task automatic write_pair(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, output bit acc);
        int n;
        n = 0;
        acc = 1'b0;
        wr_valid = 1'b1;
        wr_x = x;
        wr_y = y;
        while (!acc && n < 4) begin
            acc = wr_ready;
            tick();
            n++;
        end
        wr_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start_read = 1'b1;
        tick();
        start_read = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output int cycles);
        cycles = 0;
        while (busy && cycles < budget) begin
            tick();
            cycles++;
        end
        check("idle_timeout", busy, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit acc;
        int n;
        bit pat[5];
        logic [WIDTH-1:0] bx[3];
        logic [WIDTH-1:0] by[3];

        // Reset state
        do_reset(2);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_wr_ready", wr_ready, 1);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_rd_x", rd_x, 0);
        check("rst_rd_y", rd_y, 0);
        check("rst_rd_last", rd_last, 0);

        // Write 5 pairs then drain with rd_ready held high
        for (int i = 1; i <= 5; i++) begin
            write_pair(WIDTH'(i), WIDTH'(100 + i), acc);
            check("wd_accept", acc, 1);
        end
        check("wd_count", count, 5);
        clear_log();
        pulse_start();
        rd_ready = 1'b1;
        check("wd_busy_after_start", busy, 1);
        check("wd_valid_after_start", rd_valid, 0);
        tick();
        check("wd_valid_second_edge", rd_valid, 1);
        check("wd_first_x", rd_x, 1);
        check("wd_first_y", rd_y, 101);
        wait_idle(50, n);
        check("wd_log_size", log_x.size(), 5);
        for (int i = 0; i < 5 && i < log_x.size(); i++) begin
            check("wd_x", log_x[i], i + 1);
            check("wd_y", log_y[i], i + 101);
            check("wd_last", log_last[i], i == 4);
        end
        check("wd_end_count", count, 0);
        check("wd_end_busy", busy, 0);

        // Full boundary
        do_reset(1);
        for (int i = 0; i <= DEPTH; i++) begin
            write_pair(WIDTH'(i), WIDTH'(1000 + i), acc);
            if (i < DEPTH) check("fb_accept", acc, 1);
            else check("fb_accept_151st", acc, OVW);
            if (i == DEPTH - 1) begin
                check("fb_full", full, 1);
                check("fb_wr_ready", wr_ready, OVW);
            end
        end
        clear_log();
        rd_ready = 1'b1;
        pulse_start();
        wait_idle(400, n);
        check("fb_drain_cycles", n, DEPTH + 1);
        check("fb_log_size", log_x.size(), DEPTH);
        for (int i = 0; i < DEPTH && i < log_x.size(); i++) begin
            check("fb_x", log_x[i], i + int'(OVW));
            check("fb_last", log_last[i], i == DEPTH - 1);
        end

        // Back-pressure with rd_ready 1,0,0,1,1
        do_reset(1);
        rd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bx[i] = WIDTH'($urandom);
            by[i] = WIDTH'($urandom);
            write_pair(bx[i], by[i], acc);
        end
        clear_log();
        pulse_start();
        tick();
        check("bp_valid", rd_valid, 1);
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 5; k++) begin
            rd_ready = pat[k];
            tick();
        end
        rd_ready = 1'b0;
        check("bp_busy_done", busy, 0);
        check("bp_log_size", log_x.size(), 3);
        for (int i = 0; i < 3 && i < log_x.size(); i++) begin
            check("bp_x", log_x[i], bx[i]);
            check("bp_y", log_y[i], by[i]);
            check("bp_last", log_last[i], i == 2);
        end

        // start_read on empty buffer is ignored
        do_reset(1);
        pulse_start();
        check("se_busy", busy, 0);
        tick();
        check("se_busy_later", busy, 0);
        check("se_rd_valid", rd_valid, 0);

        // start_read together with a write on an empty buffer
        clear_log();
        wr_valid = 1'b1;
        wr_x = 7;
        wr_y = 8;
        start_read = 1'b1;
        tick();
        wr_valid = 1'b0;
        start_read = 1'b0;
        rd_ready = 1'b1;
        check("sw_busy", busy, 1);
        wait_idle(10, n);
        check("sw_log_size", log_x.size(), 1);
        if (log_x.size() > 0) begin
            check("sw_x", log_x[0], 7);
            check("sw_y", log_y[0], 8);
            check("sw_last", log_last[0], 1);
        end

        // Reset mid-drain
        do_reset(1);
        for (int i = 0; i < 10; i++) write_pair(WIDTH'(i * 3), WIDTH'(i * 5 + 2), acc);
        clear_log();
        rd_ready = 1'b1;
        pulse_start();
        n = 0;
        while (log_x.size() < 4 && n < 20) begin
            tick();
            n++;
        end
        check("rm_reads", log_x.size(), 4);
        do_reset(1);
        check("rm_count", count, 0);
        check("rm_rd_valid", rd_valid, 0);
        check("rm_busy", busy, 0);
        check("rm_empty", empty, 1);
        write_pair(20'hABCDE, 20'h12345, acc);
        clear_log();
        pulse_start();
        wait_idle(10, n);
        check("rm_log_size", log_x.size(), 1);
        if (log_x.size() > 0) begin
            check("rm_x", log_x[0], 20'hABCDE);
            check("rm_y", log_y[0], 20'h12345);
        end

        // Randomized traffic: frequent drains, then rare drains to reach full
        for (int p = 0; p < 2; p++) begin
            for (int c = 0; c < 3000; c++) begin
                wr_valid   = ($urandom_range(0, 3) != 0);
                wr_x       = WIDTH'($urandom);
                wr_y       = WIDTH'($urandom);
                start_read = (p == 0) ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 399) == 0);
                rd_ready   = ($urandom_range(0, 2) != 0);
                rst        = ($urandom_range(0, 1499) == 0);
                tick();
            end
        end

        wr_valid = 1'b0;
        start_read = 1'b0;
        rd_ready = 1'b0;
        do_reset(1);
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vector_writer.md
# vector_writer

Capture buffer at the output end of the vector datapath. It accepts (X, Y) 20-bit vector pairs from the compute pipeline over a valid/ready handshake and stores up to 150 pairs in order. On command it drains them oldest-first over a second valid/ready stream, for the checker or host-side dump logic. It mirrors the sample loader: the loader feeds vectors in, this block collects them on the way out.

## Interface
- WIDTH, 20, bit width of each vector component
- DEPTH, 150, number of stored (X, Y) pairs
- CW, $clog2(DEPTH+1), width of count
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- wr_valid  input  1  producer offers wr_x/wr_y
- wr_ready  output  1  block accepts the pair this cycle
- wr_x  input  WIDTH  X component to store
- wr_y  input  WIDTH  Y component to store
- start_read  input  1  single-cycle pulse, begin drain
- rd_valid  output  1  rd_x/rd_y hold a stored pair
- rd_ready  input  1  consumer takes the pair this cycle
- rd_x  output  WIDTH  drained X
- rd_y  output  WIDTH  drained Y
- rd_last  output  1  current rd pair is the final stored entry
- count  output  CW  number of pairs currently stored
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- busy  output  1  FSM in DRAIN

## Operation
- Storage: two WIDTH x DEPTH arrays plus wr_ptr and rd_ptr. Both pointers wrap DEPTH-1 -> 0; they never take values >= DEPTH.
- States: IDLE, DRAIN.
- IDLE:
  - wr_ready = !full.
  - A write handshake (wr_valid && wr_ready) stores the pair at wr_ptr, advances wr_ptr and increments count.
- IDLE -> DRAIN on start_read && !empty. start_read while empty is ignored and the FSM stays in IDLE.
- start_read in the same cycle as a write handshake: the write is stored first and is included in the drain.
- DRAIN:
  - wr_ready = 0 and start_read is ignored.
  - Pairs are presented in write order starting at rd_ptr.
  - On each rd_valid && rd_ready, rd_ptr advances and count decrements.
  - rd_last = rd_valid && (count == 1).
- DRAIN -> IDLE on the handshake of the rd_last pair. In that cycle rd_valid falls and wr_ptr and rd_ptr both return to 0.
- Hold rule: while rd_valid && !rd_ready, rd_x, rd_y and rd_last stay stable.
- Reset: clears state to IDLE, wr_ptr = rd_ptr = 0, count = 0.
  - Output values after reset: wr_ready = 1, rd_valid = 0, rd_x = rd_y = 0, rd_last = 0, full = 0, empty = 1, busy = 0.
  - Memory contents are not cleared.
  - Reset during DRAIN aborts the drain immediately and discards all stored data.

## Timing
- Write: a pair accepted at edge N is reflected in count/full/empty after edge N.
- Drain latency: start_read sampled at edge N gives busy = 1 after N and rd_valid = 1 after edge N+1, carrying the oldest pair.
- Throughput: with rd_ready held high, one pair per cycle. A full buffer drains in DEPTH consecutive cycles, then busy falls after the final handshake edge.
- The rd output registers update only on a read handshake or on the first fetch. The memory read is registered, and the next pair is prefetched so there are no bubbles.
- All outputs are registered, except wr_ready, full, empty and rd_last, which decode registered state.

## Configuration
- VECTOR_WRITER_OVERWRITE_EN defined:
  - In IDLE, wr_ready = 1 even when full.
  - A write while full overwrites the oldest entry: the pair is stored at wr_ptr, and both wr_ptr and rd_ptr advance.
  - count stays DEPTH, so the buffer keeps the most recent DEPTH pairs.
- Not defined: writes while full are back-pressured (wr_ready = 0) and no data is lost.

## Test plan
- Reset state: assert rst for 2 cycles -> count = 0, empty = 1, full = 0, wr_ready = 1, rd_valid = 0, busy = 0.
- Write then drain: write X = 1..5 and Y = 101..105, pulse start_read, hold rd_ready = 1.
  - rd_valid rises 2 edges after start_read.
  - Outputs are (1,101) … (5,105) on consecutive cycles, rd_last only on (5,105).
  - Afterwards count = 0 and busy = 0.
- Full boundary: write 151 pairs (X = n for n = 0..150).
  - Without the macro: full = 1 after 150 writes, wr_ready = 0, pair 150 stalls, and the drain yields X = 0..149.
  - With the macro: the drain yields X = 1..150.
- Back-pressure: drain 3 stored pairs while toggling rd_ready 1,0,0,1,1 -> each pair is held stable while rd_ready = 0, no pair is duplicated or skipped, and rd_last holds on the third pair.
- Edge events:
  - start_read while empty -> busy stays 0.
  - start_read in the same cycle as a write of (7,8) on an empty buffer -> drain emits exactly (7,8) with rd_last = 1.
- Reset mid-drain: store 10 pairs, start drain, assert rst after 4 reads -> after reset count = 0, rd_valid = 0 and busy = 0; a following write/drain of 1 pair returns that pair.
